// File: rtl/pong_message_receiver.sv
// UART receive end of the inter-board pong link: 8N1 bytes -> 4-byte checked frames ->
// decoded ball / miss / new-game / new-game-ack messages held under a pending/ack handshake.
module pong_message_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic       UART_CTS,
  output logic       new_message_received,
  input  logic       message_acked,
  output logic [8:0] ball_y_rx,
  output logic [3:0] velocity_x_rx,
  output logic [3:0] velocity_y_rx,
  output logic       ball_message_rx,
  output logic [4:0] my_score_rx,
  output logic [4:0] your_score_rx,
  output logic       you_should_serve_rx,
  output logic       miss_message_rx,
  output logic       you_serve_first_rx,
  output logic       new_game_message_rx,
  output logic       new_game_ack_message_rx,
  output logic       frame_error,
  output logic [7:0] drop_count
);

  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW             = $clog2(CLKS_PER_BIT);
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_B1, P_B2, P_CS} parse_state_t;

  rx_state_t    rx_state;
  parse_state_t parse_state;

  logic          rxd_meta, rxd_sync, rxd_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_valid, byte_err;
  logic [7:0]    hdr, p0, p1;
  logic [TW-1:0] idle_cnt;
  logic          hdr_ok, good_frame;

  // Synchroniser idles high so reset never fabricates a start-bit edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= UART_RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (rxd_prev && !rxd_sync) rx_state <= RX_START;
        end
        RX_START: begin
          // Mid-start re-sample: a line already back high was only a glitch.
          if (clk_cnt == CW'(HALF_BIT - 1)) begin
            clk_cnt  <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            rx_byte <= {rxd_sync, rx_byte[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt    <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rxd_sync;
            byte_err   <= !rxd_sync;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign hdr_ok     = (rx_byte[7:4] == 4'hA) && !rx_byte[1];
  assign good_frame = byte_valid && (parse_state == P_CS) && ((hdr ^ p0 ^ p1) == rx_byte);

  always_ff @(posedge clock) begin
    if (reset) begin
      parse_state <= P_HUNT;
      hdr         <= '0;
      p0          <= '0;
      p1          <= '0;
      idle_cnt    <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (byte_err) begin
        parse_state <= P_HUNT;
        idle_cnt    <= '0;
        frame_error <= 1'b1;
      end else if (byte_valid) begin
        idle_cnt <= '0;
        case (parse_state)
          P_HUNT: begin
            if (hdr_ok) begin
              hdr         <= rx_byte;
              parse_state <= P_B1;
            end else begin
              frame_error <= 1'b1;
            end
          end
          P_B1: begin
            p0          <= rx_byte;
            parse_state <= P_B2;
          end
          P_B2: begin
            p1          <= rx_byte;
            parse_state <= P_CS;
          end
          default: begin
            parse_state <= P_HUNT;
            if (!good_frame) frame_error <= 1'b1;
          end
        endcase
      end else if (parse_state != P_HUNT) begin
        // A stalled partial frame is abandoned so the next header can resync.
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          parse_state <= P_HUNT;
          idle_cnt    <= '0;
          frame_error <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Handshake: new_message_received is "valid", message_acked is "ready"; a message transfers
  // on any edge where both are high. Payload is frozen while valid is high, and a frame that
  // completes on the transfer edge is loaded in its place, keeping valid asserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      new_message_received    <= 1'b0;
      ball_y_rx               <= '0;
      velocity_x_rx           <= '0;
      velocity_y_rx           <= '0;
      ball_message_rx         <= 1'b0;
      my_score_rx             <= '0;
      your_score_rx           <= '0;
      you_should_serve_rx     <= 1'b0;
      miss_message_rx         <= 1'b0;
      you_serve_first_rx      <= 1'b0;
      new_game_message_rx     <= 1'b0;
      new_game_ack_message_rx <= 1'b0;
      drop_count              <= '0;
    end else if (good_frame && (!new_message_received || message_acked)) begin
      new_message_received    <= 1'b1;
      ball_y_rx               <= '0;
      velocity_x_rx           <= '0;
      velocity_y_rx           <= '0;
      ball_message_rx         <= 1'b0;
      my_score_rx             <= '0;
      your_score_rx           <= '0;
      you_should_serve_rx     <= 1'b0;
      miss_message_rx         <= 1'b0;
      you_serve_first_rx      <= 1'b0;
      new_game_message_rx     <= 1'b0;
      new_game_ack_message_rx <= 1'b0;
      case (hdr[3:2])
        2'b00: begin
          ball_message_rx <= 1'b1;
          ball_y_rx       <= {hdr[0], p0};
          velocity_x_rx   <= p1[7:4];
          velocity_y_rx   <= p1[3:0];
        end
        2'b01: begin
          miss_message_rx     <= 1'b1;
          my_score_rx         <= p0[7:3];
          your_score_rx       <= {p0[2:0], p1[7:6]};
          you_should_serve_rx <= p1[5];
        end
        2'b10: begin
          new_game_message_rx <= 1'b1;
          you_serve_first_rx  <= p0[0];
        end
        default: new_game_ack_message_rx <= 1'b1;
      endcase
    end else if (good_frame) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end else if (new_message_received && message_acked) begin
      new_message_received    <= 1'b0;
      ball_message_rx         <= 1'b0;
      miss_message_rx         <= 1'b0;
      new_game_message_rx     <= 1'b0;
      new_game_ack_message_rx <= 1'b0;
    end
  end

  assign UART_CTS = new_message_received;

endmodule
